imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Writer side of the instruction-memory fetch path. The CPU only reads instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Drives a word write port into instruction memory.
- Holds the CPU core in reset until a complete, checksum-verified image has been written.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address.
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word.
- DEPTH, 256, maximum image size in words.
- LEN_W, 16, width of the length header field.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a load; sampled only in IDLE or ERR.
- in_valid  input  1  byte-stream data valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction-memory word write strobe.
- imem_addr  output  ADDR_W  byte address of the write, word aligned.
- imem_wdata  output  32  instruction word to write.
- cpu_rst  output  1  reset to CPU core (fetch PC, register file).
- busy  output  1  a load is in progress.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  sticky error flag.
- words_loaded  output  LEN_W  number of words written in the current or last load.

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_rst=1, busy=0, done=0, err=0, words_loaded=0, state=IDLE.
- Reset mid-load aborts the load and returns to IDLE. Words already written stay in memory, and cpu_rst stays 1.
- A byte is accepted on any cycle with in_valid and in_ready both high. in_ready is a registered-state decode: high in LEN_LO, LEN_HI, DATA and CHK, low elsewhere.
- Stream format: len[7:0], len[15:8], then len×4 payload bytes (least-significant byte first per word), then one checksum byte equal to the XOR of all payload bytes.
- States:
  - IDLE. On start: cpu_rst<=1, busy<=1, err<=0, words_loaded<=0, checksum accumulator<=0, byte index<=0, go to LEN_LO.
  - LEN_LO. On accept, latch the low byte and go to LEN_HI.
  - LEN_HI. On accept, latch the high byte. If len>DEPTH, go to ERR with no writes. If len==0, go to CHK. Otherwise go to DATA.
  - DATA. On accept, shift the byte into word buffer lane [byte index], XOR it into the checksum, and increment byte index mod 4.
    - On the 4th byte: the next cycle has imem_we=1, imem_wdata=assembled word, imem_addr=BASE_ADDR+4×words_loaded (pre-increment value); words_loaded increments.
    - After the len-th word is accepted, go to CHK.
    - imem_we is a single-cycle pulse per word. Back-to-back words may produce imem_we on consecutive cycles at full stream rate.
  - CHK. On accept, compare the byte with the accumulator. Match: go to DONE. Mismatch: go to ERR.
  - DONE. One cycle: done=1, cpu_rst<=0, busy<=0, then go to IDLE. The CPU leaves reset the cycle after done.
  - ERR. err=1 (sticky), busy=0, cpu_rst=1, in_ready=0. Leaves only on start (re-enters LEN_LO, clears err) or rst.
- start is ignored while busy. A stall (in_valid low) in any state holds all state with no timeout.
- The address offset wraps modulo 2^ADDR_W. This is unreachable given the DEPTH check, but no saturation logic is needed.
- The final word's imem_we fires in the cycle after its 4th byte, which may coincide with the CHK state. done never precedes the last write.

Decomposition:
- Shared package:
  - state enumeration constants (IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR).
  - a word-size constant of 4 bytes.
  - the checksum-width constant.
- One natural sub-module: imem_word_assembler. It holds the byte-lane shift register, the 2-bit byte index, and the write-pulse generation. It outputs a word_valid pulse plus the word. The FSM remains in the top.

Test Plan:
- Nominal two-word load: start, then bytes 02 00 13 05 A0 00 93 05 50 00 70.
  - Writes 0x00A00513@0x0 and 0x00500593@0x4.
  - done pulses once, cpu_rst falls the next cycle, words_loaded=2, err=0.
- Bad checksum: same stream with last byte 71.
  - Both writes occur, then err=1, cpu_rst stays 1, done never asserts.
  - A new start clears err.
- Oversize header: with DEPTH=256, send bytes 01 01 (len=257).
  - ERR right after the 2nd byte, zero imem_we pulses, in_ready=0.
- Zero length: bytes 00 00 00.
  - No writes, done=1, cpu_rst=0. Zero-length bytes 00 00 then 01 instead leads to ERR.
- Back-pressure: in_valid toggles 1-0-1 on every byte of the nominal stream.
  - Identical writes and addresses to the nominal case, one imem_we per 4 accepted bytes, no duplicate writes.
- Reset mid-load: assert rst after 6 payload bytes.
  - One write has occurred, all outputs return to reset values, and a subsequent full nominal load succeeds.

Source files
------------

// File: rtl/imem_program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_program_loader_pkg
// Brief    : Shared constants and state encoding for the instruction-memory
//            program loader.
// Revision : 1.0 - initial release
// ============================================================================
package imem_program_loader_pkg;

    localparam int c_WORD_BYTES = 4;
    localparam int c_CHK_W      = 8;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LEN_LO = 3'd1;
    localparam logic [2:0] c_ST_LEN_HI = 3'd2;
    localparam logic [2:0] c_ST_DATA   = 3'd3;
    localparam logic [2:0] c_ST_CHK    = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;
    localparam logic [2:0] c_ST_ERR    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = c_ST_IDLE,
        S_LEN_LO = c_ST_LEN_LO,
        S_LEN_HI = c_ST_LEN_HI,
        S_DATA   = c_ST_DATA,
        S_CHK    = c_ST_CHK,
        S_DONE   = c_ST_DONE,
        S_ERR    = c_ST_ERR
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : imem_word_assembler
// Brief    : Packs little-endian bytes into words and emits a one-cycle
//            word_valid pulse the cycle after the last byte of each word.
// Revision : 1.0 - initial release
// ============================================================================
module imem_word_assembler
    import imem_program_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_data,
    output logic                      last_byte,
    output logic                      word_valid,
    output logic [8*c_WORD_BYTES-1:0] word
);

    logic [1:0]                r_idx;
    logic [8*c_WORD_BYTES-1:0] r_buf;
    logic [8*c_WORD_BYTES-1:0] r_word;
    logic                      r_word_valid;
    logic [8*c_WORD_BYTES-1:0] w_next_buf;

    // Lane selected by the running byte index, so the LSB arrives first.
    always_comb begin
        w_next_buf = r_buf;
        w_next_buf[{r_idx, 3'b000} +: 8] = byte_data;
    end

    assign last_byte  = (r_idx == 2'(c_WORD_BYTES - 1));
    assign word_valid = r_word_valid;
    assign word       = r_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= 2'd0;
            r_buf        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (clear) begin
                r_idx <= 2'd0;
            end else if (byte_valid) begin
                r_buf <= w_next_buf;
                r_idx <= r_idx + 2'd1;
                if (last_byte) begin
                    r_word       <= w_next_buf;
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_program_loader
// Brief    : Loads a length-prefixed, XOR-checked byte image into instruction
//            memory and holds the CPU in reset until the image verifies.
// Revision : 1.0 - initial release
// ============================================================================
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 256,
    parameter int                LEN_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  words_loaded
);

    state_t             r_state;
    logic [15:0]        r_len;
    logic [c_CHK_W-1:0] r_chk;
    logic [ADDR_W-1:0]  r_imem_addr;
    logic               r_cpu_rst;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [LEN_W-1:0]   r_words;

    logic               w_accept;
    logic               w_start_load;
    logic               w_last_byte;
    logic [15:0]        w_len_hdr;
    logic [LEN_W-1:0]   w_words_next;
    logic [ADDR_W-1:0]  w_offset;

    assign in_ready     = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                          (r_state == S_DATA)   || (r_state == S_CHK);
    assign w_accept     = in_valid && in_ready;
    assign w_start_load = start && ((r_state == S_IDLE) || (r_state == S_ERR));
    assign w_len_hdr    = {in_data, r_len[7:0]};
    assign w_words_next = r_words + LEN_W'(1);
    assign w_offset     = ADDR_W'(r_words) << 2;

    imem_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_start_load),
        .byte_valid (w_accept && (r_state == S_DATA)),
        .byte_data  (in_data),
        .last_byte  (w_last_byte),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    assign imem_addr    = r_imem_addr;
    assign cpu_rst      = r_cpu_rst;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_words;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_chk       <= '0;
            r_imem_addr <= BASE_ADDR;
            r_cpu_rst   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_words     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_ERR: begin
                    if (w_start_load) begin
                        r_cpu_rst <= 1'b1;
                        r_busy    <= 1'b1;
                        r_err     <= 1'b0;
                        r_words   <= '0;
                        r_chk     <= '0;
                        r_state   <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= in_data;
                        r_state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len[15:8] <= in_data;
                        if (32'(w_len_hdr) > 32'(DEPTH)) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_ERR;
                        end else if (w_len_hdr == 16'd0) begin
                            r_state <= S_CHK;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_chk <= r_chk ^ in_data;
                        // Address is latched with the pre-increment count and
                        // lines up with the assembler's write pulse next cycle.
                        if (w_last_byte) begin
                            r_imem_addr <= BASE_ADDR + w_offset;
                            r_words     <= w_words_next;
                            if (w_words_next == LEN_W'(r_len)) begin
                                r_state <= S_CHK;
                            end
                        end
                    end
                end
                S_CHK: begin
                    if (w_accept) begin
                        if (in_data == r_chk) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_ERR;
                        end
                    end
                end
                S_DONE: begin
                    r_cpu_rst <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_program_loader
// Brief    : Randomised scoreboard bench for the instruction-memory loader.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_program_loader;

    localparam int          ADDR_W    = 32;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int          DEPTH     = 256;
    localparam int          LEN_W     = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [LEN_W-1:0]  words_loaded;

    imem_program_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .DEPTH     (DEPTH),
        .LEN_W     (LEN_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] pay_q[$];
    int          checks = 0;
    int          errors = 0;
    int          writes_seen = 0;
    int          done_seen = 0;
    logic        prev_done = 1'b0;
    wr_t         mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every write and done pulse is matched against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done = 1'b0;
            end else begin
                if (prev_done) check("cpu_rst_after_done", 32'(cpu_rst), 32'd0);
                if (imem_we) begin
                    writes_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write actual addr=%0h data=%0h required no write",
                                 imem_addr, imem_wdata);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("wr_addr", imem_addr, mon_e.addr);
                        check("wr_data", imem_wdata, mon_e.data);
                    end
                end
                if (done) begin
                    done_seen++;
                    check("writes_pending_at_done", 32'(exp_q.size()), 32'd0);
                end
                prev_done = done;
            end
        end
    end

    task automatic check_reset_values();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", imem_addr, BASE_ADDR);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bp);
        int n = 0;
        if (bp) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout actual in_ready=0 required 1");
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_expected(input int len);
        wr_t e;
        for (int i = 0; i < len; i++) begin
            e.addr = BASE_ADDR + 32'(4 * i);
            e.data = pay_q[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic set_nominal();
        pay_q.delete();
        pay_q.push_back(32'h00A0_0513);
        pay_q.push_back(32'h0050_0593);
    endtask

    task automatic set_random(input int len);
        pay_q.delete();
        for (int i = 0; i < len; i++) pay_q.push_back($urandom());
    endtask

    // Full load transaction; mask is XORed into the true checksum byte.
    task automatic run_load(input int len, input logic [7:0] mask, input bit bp, input bit noise);
        logic [7:0]  x = 8'h00;
        logic [31:0] w;
        int          d0 = done_seen;
        int          w0 = writes_seen;
        bit          over = (len > DEPTH);
        do_start();
        check("busy_after_start", 32'(busy), 32'd1);
        check("err_after_start", 32'(err), 32'd0);
        check("cpu_rst_after_start", 32'(cpu_rst), 32'd1);
        if (!over) push_expected(len);
        send_byte(8'(len), bp);
        send_byte(8'(len >> 8), bp);
        if (over) begin
            check("oversize_err", 32'(err), 32'd1);
            check("oversize_in_ready", 32'(in_ready), 32'd0);
            check("oversize_busy", 32'(busy), 32'd0);
            check("oversize_cpu_rst", 32'(cpu_rst), 32'd1);
            repeat (3) @(negedge clk);
            #1;
            check("oversize_writes", 32'(writes_seen - w0), 32'd0);
            check("oversize_words_loaded", 32'(words_loaded), 32'd0);
            return;
        end
        if (noise) start = 1'b1;
        for (int i = 0; i < len; i++) begin
            w = pay_q[i];
            for (int b = 0; b < 4; b++) begin
                x ^= w[8*b +: 8];
                send_byte(w[8*b +: 8], bp);
            end
        end
        start = 1'b0;
        send_byte(x ^ mask, bp);
        if (mask == 8'h00) begin
            check("done_pulse", 32'(done), 32'd1);
            check("err_ok", 32'(err), 32'd0);
            @(negedge clk);
            #1;
            check("cpu_rst_released", 32'(cpu_rst), 32'd0);
            check("busy_cleared", 32'(busy), 32'd0);
            check("done_one_cycle", 32'(done), 32'd0);
        end else begin
            check("err_flag", 32'(err), 32'd1);
            check("done_on_bad", 32'(done), 32'd0);
            check("err_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            #1;
            check("cpu_rst_held", 32'(cpu_rst), 32'd1);
            check("err_sticky", 32'(err), 32'd1);
        end
        check("words_loaded", 32'(words_loaded), 32'(len));
        check("done_count", 32'(done_seen - d0), (mask == 8'h00) ? 32'd1 : 32'd0);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        check("write_count", 32'(writes_seen - w0), 32'(len));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int len;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);

        set_nominal();
        run_load(2, 8'h00, 1'b0, 1'b0);
        set_nominal();
        run_load(2, 8'h01, 1'b0, 1'b0);
        run_load(257, 8'h00, 1'b0, 1'b0);
        pay_q.delete();
        run_load(0, 8'h00, 1'b0, 1'b0);
        run_load(0, 8'h01, 1'b0, 1'b0);
        set_nominal();
        run_load(2, 8'h00, 1'b1, 1'b0);

        set_nominal();
        w0 = writes_seen;
        do_start();
        push_expected(2);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int k = 0; k < 6; k++) begin
            logic [31:0] v;
            v = pay_q[k / 4];
            send_byte(v[8*(k%4) +: 8], 1'b0);
        end
        @(negedge clk);
        #1;
        check("midload_writes", 32'(writes_seen - w0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_reset_values();
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        set_nominal();
        run_load(2, 8'h00, 1'b0, 1'b0);

        set_random(DEPTH);
        run_load(DEPTH, 8'h00, 1'b0, 1'b0);

        repeat (25) begin
            if ($urandom_range(0, 7) == 0) begin
                run_load(DEPTH + 1 + int'($urandom_range(0, 200)), 8'h00, 1'b0, 1'b0);
            end else begin
                len = int'($urandom_range(0, 6));
                set_random(len);
                run_load(len, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
